fifo_stream_out: RTL and testbench
==================================

FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32, the data word width.
REQ-002 SHALL have parameter NUM_BRAM_ADDR_BITS, default 9, the RAM address width.
REQ-003 SHALL have localparam FIFO_DEPTH = 2**NUM_BRAM_ADDR_BITS, the RAM entry count.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port wdata, input, PAYLOAD_BITS, the write word from the producer.
REQ-007 SHALL have port winc, input, 1, the write strobe.
REQ-008 SHALL have port wfull, output, 1, high when the RAM holds FIFO_DEPTH entries.
REQ-009 SHALL have port dout, output, PAYLOAD_BITS, the downstream stream data.
REQ-010 SHALL have port val_out, output, 1, the downstream valid.
REQ-011 SHALL have port ready_downward, input, 1, the downstream ready.
REQ-012 SHALL have port ovf, output, 1, the sticky overflow flag.
REQ-013 SHALL have port count, output, NUM_BRAM_ADDR_BITS+2, the total words held.

Function
REQ-014 SHALL store words in a circular RAM with synchronous read.
- Read and write pointers are NUM_BRAM_ADDR_BITS+1 wide; the extra bit is the wrap bit.
- empty = pointers equal; full = addresses equal and wrap bits differ.
REQ-015 SHALL write wdata on a cycle with winc=1 and wfull=0; a winc while wfull=1 is dropped and the RAM is unchanged.
REQ-016 SHALL compute wfull from registered pointers; a same-cycle RAM read does not admit a write while wfull=1.
REQ-017 SHALL place a two-entry output buffer (main + skid) after the RAM; dout/val_out come from the main entry.
REQ-018 SHALL issue a RAM read in a cycle when the RAM is non-empty and (buffered entries + in-flight reads - (val_out&ready_downward)) <= 1.
REQ-019 SHALL use the pre-edge RAM state for the read decision; a word written in cycle N is never read in cycle N.
REQ-020 SHALL give latency: winc in cycle 0 into a fully empty block -> val_out=1 with that word in cycle 2.
REQ-021 SHALL hold dout and val_out stable while val_out=1 and ready_downward=0.
REQ-022 SHALL complete a transfer on a cycle with val_out=1 and ready_downward=1; the skid entry (or read data) becomes main on the next cycle.
REQ-023 SHALL sustain one word per cycle when ready_downward stays 1 and the RAM is non-empty.
REQ-024 SHALL never lose read data when ready_downward drops with a read in flight; the skid entry absorbs it.
REQ-025 SHALL deliver words in write order, across pointer wrap-around, with no duplication.
REQ-026 SHALL drive val_out to 0 exactly when the output buffer is empty.

Reset
REQ-027 SHALL, on reset assertion, immediately clear pointers, output buffer, in-flight flag, ovf and count.
- Outputs during reset: wfull=0, val_out=0, dout=0.
REQ-028 SHALL discard all held data when reset asserts mid-operation; first valid output occurs no earlier than 2 cycles after the first post-reset write.

Configuration
REQ-029 SHALL, with macro FIFO_STREAM_OUT_STATS_EN defined, set ovf on any dropped write (held until reset) and drive count = RAM entries + in-flight + buffered words.
REQ-030 SHALL, without FIFO_STREAM_OUT_STATS_EN, tie ovf=0 and count=0 with no counter logic; all other behaviour is identical.

Structure
REQ-031 SHALL put the pointer-width helper constant and output-buffer state encoding (EMPTY, ONE, TWO) in shared package fifo_stream_pkg.
REQ-032 SHALL implement storage as sub-module stream_out_ram: simple dual-port, one write port, one registered read port.

Verification
REQ-033 SHALL cover: write 0xA5 in cycle 0, ready_downward=1 -> val_out=1, dout=0xA5 in cycle 2 and val_out=0 in cycle 3.
REQ-034 SHALL cover: write 1..FIFO_DEPTH+2 with ready_downward=0 -> wfull=1 at RAM-full; writes past capacity dropped; ovf=1 (macro on); drain yields only accepted words, in order.
REQ-035 SHALL cover: continuous writes of 0..1023 with ready_downward=1 -> one word per cycle after the 2-cycle fill, in order, with wrap-around.
REQ-036 SHALL cover: ready_downward toggling pseudo-randomly during streaming -> no loss or duplication, and dout stable while stalled.
REQ-037 SHALL cover: reset pulse with 10 words held -> val_out=0 and wfull=0 immediately, count=0, and no stale word appears afterwards.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg
// Shared definitions for fifo_stream_out and its RAM sub-module:
//   - ptr_width(): width of the read/write pointers (address bits + wrap bit)
//   - buf_state_t: occupancy encoding of the two-entry output buffer
//   - buf_count(): number of words held for a given buffer state
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    function automatic int ptr_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic logic [1:0] buf_count(input buf_state_t s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/stream_out_ram.sv
// stream_out_ram
// Simple dual-port storage: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word;
// the FIFO never does this because its read and write addresses differ
// whenever a read is issued.
// Ports:
//   clk      - clock, rising edge
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_re     - read enable; o_rdata updates on the next rising edge
//   i_raddr  - read address
//   o_rdata  - registered read data (holds when i_re=0)
module stream_out_ram
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_stream_out.sv
// fifo_stream_out
// Circular-RAM FIFO with a valid/ready streaming output. A two-entry output
// buffer (main + skid) sits behind the synchronous-read RAM so the stream can
// run at one word per cycle and a stall never loses a word already being read.
//
// Optional feature macro: FIFO_STREAM_OUT_STATS_EN
//   defined   -> ovf is a sticky dropped-write flag, count = words held
//   undefined -> ovf = 0, count = 0, no counter logic
//
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous, active-high
//   wdata / winc   - producer word and write strobe (dropped while wfull=1)
//   wfull          - RAM holds FIFO_DEPTH entries
//   dout / val_out - downstream data and valid
//   ready_downward - downstream ready
//   ovf            - sticky overflow flag
//   count          - RAM entries + in-flight read + buffered words
//
// Output buffer states:
//   state | meaning
//   EMPTY | no word in main/skid (a landed RAM read may still be presented)
//   ONE   | main holds the presented word
//   TWO   | main presented, skid holds the following word
//
// A word read from the RAM is presented straight from the RAM output register
// in the cycle it lands (r_rd_vld); it only moves into main/skid if it is not
// consumed that cycle. This is what gives the two-cycle write-to-valid latency.
module fifo_stream_out
    import fifo_stream_pkg::*;
#(
    parameter int PAYLOAD_BITS       = 32,
    parameter int NUM_BRAM_ADDR_BITS = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PAYLOAD_BITS-1:0]       wdata,
    input  logic                          winc,
    output logic                          wfull,
    output logic [PAYLOAD_BITS-1:0]       dout,
    output logic                          val_out,
    input  logic                          ready_downward,
    output logic                          ovf,
    output logic [NUM_BRAM_ADDR_BITS+1:0] count
);

    localparam int FIFO_DEPTH = 2**NUM_BRAM_ADDR_BITS;
    localparam int AW         = NUM_BRAM_ADDR_BITS;
    localparam int PTR_W      = ptr_width(NUM_BRAM_ADDR_BITS);

    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic                    r_rd_vld;
    buf_state_t              r_state;
    buf_state_t              w_state_nxt;
    logic [PAYLOAD_BITS-1:0] r_main;
    logic [PAYLOAD_BITS-1:0] r_skid;
    logic [PAYLOAD_BITS-1:0] w_rdata;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic                    w_pop;
    logic [2:0]              w_pending;
    logic                    w_main_from_ram;
    logic                    w_main_from_skid;
    logic                    w_skid_from_ram;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_wr_en = winc & ~w_full;
    assign wfull   = w_full;

    assign val_out = (r_state != EMPTY) | r_rd_vld;
    assign dout    = (r_state != EMPTY) ? r_main : (r_rd_vld ? w_rdata : '0);
    assign w_pop   = val_out & ready_downward;

    // Words that would still be held after this edge without a new read.
    // w_pop implies at least one word held, so this never underflows.
    assign w_pending = {1'b0, buf_count(r_state)} + {2'b00, r_rd_vld} - {2'b00, w_pop};
    assign w_rd_en   = ~w_empty & (w_pending <= 3'd1);

    stream_out_ram #(
        .DATA_W (PAYLOAD_BITS),
        .ADDR_W (AW),
        .DEPTH  (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (wdata),
        .i_re    (w_rd_en),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_rd_vld <= w_rd_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_ram  = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_ram  = 1'b0;
        case (r_state)
            EMPTY: begin
                if (r_rd_vld && !w_pop) begin
                    w_state_nxt     = ONE;
                    w_main_from_ram = 1'b1;
                end
            end
            ONE: begin
                if (w_pop) begin
                    if (r_rd_vld) begin
                        w_main_from_ram = 1'b1;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end else if (r_rd_vld) begin
                    w_state_nxt     = TWO;
                    w_skid_from_ram = 1'b1;
                end
            end
            TWO: begin
                // The read gate keeps r_rd_vld low here.
                if (w_pop) begin
                    w_state_nxt      = ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_from_ram) begin
                r_main <= w_rdata;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_from_ram) begin
                r_skid <= w_rdata;
            end
        end
    end

`ifdef FIFO_STREAM_OUT_STATS_EN
    logic             r_ovf;
    logic [PTR_W-1:0] w_ram_used;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (winc && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign w_ram_used = r_wptr - r_rptr;
    assign ovf        = r_ovf;
    assign count      = (AW+2)'(w_ram_used) + (AW+2)'(r_rd_vld) + (AW+2)'(buf_count(r_state));
`else
    assign ovf   = 1'b0;
    assign count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
module tb_fifo_stream_out;

    localparam int PW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 2**AW;
    localparam int CW    = AW + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] wdata;
    logic          winc;
    logic          wfull;
    logic [PW-1:0] dout;
    logic          val_out;
    logic          ready_downward;
    logic          ovf;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_stream_out #(
        .PAYLOAD_BITS       (PW),
        .NUM_BRAM_ADDR_BITS (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wdata          (wdata),
        .winc           (winc),
        .wfull          (wfull),
        .dout           (dout),
        .val_out        (val_out),
        .ready_downward (ready_downward),
        .ovf            (ovf),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; winc = 1'b0; wdata = '0; ready_downward = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({wfull, val_out} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: wfull=%b val_out=%b, want 0 0", wfull, val_out);
        end
        n_checks++;
        if (dout !== '0) begin
            n_fail++; $display("FAIL reset_dout: got %h want 0", dout);
        end
        n_checks++;
        if ({ovf, count} !== '0) begin
            n_fail++; $display("FAIL reset_stats: ovf=%b count=%0d want 0 0", ovf, count);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (val_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: val_out=%b want 0", val_out);
        end
    endtask

    task automatic test_single();
        ready_downward = 1'b1;
        winc = 1'b1; wdata = 32'h0000_00A5;
        tick();
        winc = 1'b0;
        n_checks++;
        if (val_out !== 1'b0) begin
            n_fail++; $display("FAIL single_c1: val_out=%b want 0", val_out);
        end
        tick();
        n_checks++;
        if (val_out !== 1'b1 || dout !== 32'h0000_00A5) begin
            n_fail++; $display("FAIL single_c2: val_out=%b dout=%h want 1 000000a5", val_out, dout);
        end
        tick();
        n_checks++;
        if (val_out !== 1'b0) begin
            n_fail++; $display("FAIL single_c3: val_out=%b want 0", val_out);
        end
    endtask

    // Two words leave the RAM into the output buffer while stalled, so words
    // 1..DEPTH+2 are accepted and wfull is first seen when driving DEPTH+3.
    task automatic test_fill_overflow();
        int exp_w;
        ready_downward = 1'b0;
        for (int i = 1; i <= DEPTH + 4; i++) begin
            n_checks++;
            if (wfull !== (i >= DEPTH + 3)) begin
                n_fail++; $display("FAIL fill_wfull: word %0d wfull=%b want %b", i, wfull, (i >= DEPTH + 3));
            end
            winc = 1'b1; wdata = PW'(i);
            tick();
        end
        winc = 1'b0;
        tick();
        n_checks++;
        if (wfull !== 1'b1 || val_out !== 1'b1 || dout !== 32'd1) begin
            n_fail++; $display("FAIL fill_hold: wfull=%b val_out=%b dout=%0d want 1 1 1", wfull, val_out, dout);
        end
`ifdef FIFO_STREAM_OUT_STATS_EN
        n_checks++;
        if (ovf !== 1'b1 || count !== CW'(DEPTH + 2)) begin
            n_fail++; $display("FAIL fill_stats: ovf=%b count=%0d want 1 %0d", ovf, count, DEPTH + 2);
        end
`else
        n_checks++;
        if (ovf !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL fill_stats: ovf=%b count=%0d want 0 0", ovf, count);
        end
`endif
        ready_downward = 1'b1;
        exp_w = 1;
        for (int c = 0; c < DEPTH + 16; c++) begin
            if (val_out === 1'b1) begin
                n_checks++;
                if (dout !== PW'(exp_w)) begin
                    n_fail++; $display("FAIL drain_data: got %0d want %0d", dout, exp_w);
                end
                exp_w++;
            end
            tick();
        end
        n_checks++;
        if (exp_w !== DEPTH + 3) begin
            n_fail++; $display("FAIL drain_count: words %0d want %0d", exp_w - 1, DEPTH + 2);
        end
        n_checks++;
        if (val_out !== 1'b0 || wfull !== 1'b0) begin
            n_fail++; $display("FAIL drain_end: val_out=%b wfull=%b want 0 0", val_out, wfull);
        end
    endtask

    task automatic test_stream();
        ready_downward = 1'b1;
        for (int k = 0; k < 1026; k++) begin
            if (k < 1024) begin
                winc = 1'b1; wdata = PW'(k);
            end else begin
                winc = 1'b0;
            end
            n_checks++;
            if (k < 2) begin
                if (val_out !== 1'b0) begin
                    n_fail++; $display("FAIL stream_fill: cycle %0d val_out=%b want 0", k, val_out);
                end
            end else if (val_out !== 1'b1 || dout !== PW'(k - 2)) begin
                n_fail++; $display("FAIL stream_data: cycle %0d val_out=%b dout=%0d want 1 %0d", k, val_out, dout, k - 2);
            end
            tick();
        end
        n_checks++;
        if (val_out !== 1'b0) begin
            n_fail++; $display("FAIL stream_end: val_out=%b want 0", val_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0]   pat;
        logic [PW-1:0] prev_dout;
        logic          prev_stall;
        int            exp_w;
        int            n_wr;
        pat = 16'hB38D;
        prev_stall = 1'b0; prev_dout = '0;
        exp_w = 0; n_wr = 0;
        for (int c = 0; c < 2000 && exp_w < 200; c++) begin
            ready_downward = pat[c % 16];
            if (n_wr < 200 && wfull === 1'b0) begin
                winc = 1'b1; wdata = PW'(n_wr); n_wr++;
            end else begin
                winc = 1'b0;
            end
            if (prev_stall) begin
                n_checks++;
                if (val_out !== 1'b1 || dout !== prev_dout) begin
                    n_fail++; $display("FAIL bp_stable: cycle %0d val_out=%b dout=%0d want 1 %0d", c, val_out, dout, prev_dout);
                end
            end
            if (val_out === 1'b1 && ready_downward) begin
                n_checks++;
                if (dout !== PW'(exp_w)) begin
                    n_fail++; $display("FAIL bp_data: got %0d want %0d", dout, exp_w);
                end
                exp_w++;
            end
            prev_stall = val_out & ~ready_downward;
            prev_dout  = dout;
            tick();
        end
        winc = 1'b0;
        ready_downward = 1'b1;
        n_checks++;
        if (exp_w !== 200) begin
            n_fail++; $display("FAIL bp_count: received %0d want 200", exp_w);
        end
        tick(); tick();
        n_checks++;
        if (val_out !== 1'b0) begin
            n_fail++; $display("FAIL bp_extra: val_out=%b dout=%0d want no further word", val_out, dout);
        end
    endtask

    task automatic test_reset_mid();
        ready_downward = 1'b0;
        for (int i = 0; i < 10; i++) begin
            winc = 1'b1; wdata = PW'(32'h100 + i);
            tick();
        end
        winc = 1'b0;
        tick(); tick();
        n_checks++;
        if (val_out !== 1'b1 || dout !== 32'h100) begin
            n_fail++; $display("FAIL rst_mid_held: val_out=%b dout=%h want 1 00000100", val_out, dout);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (val_out !== 1'b0 || wfull !== 1'b0 || dout !== '0) begin
            n_fail++; $display("FAIL rst_mid_out: val_out=%b wfull=%b dout=%h want 0 0 0", val_out, wfull, dout);
        end
        n_checks++;
        if (count !== '0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_stats: count=%0d ovf=%b want 0 0", count, ovf);
        end
        tick();
        reset = 1'b0;
        ready_downward = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (val_out !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_stale: cycle %0d val_out=%b dout=%h want 0", i, val_out, dout);
            end
        end
        winc = 1'b1; wdata = 32'h77;
        tick();
        winc = 1'b0;
        n_checks++;
        if (val_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_c1: val_out=%b want 0", val_out);
        end
        tick();
        n_checks++;
        if (val_out !== 1'b1 || dout !== 32'h77) begin
            n_fail++; $display("FAIL rst_mid_c2: val_out=%b dout=%h want 1 00000077", val_out, dout);
        end
        tick();
        n_checks++;
        if (val_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_c3: val_out=%b want 0", val_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_stream();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, want test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
